bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the iterative shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the team's BCD-to-Excess-3 code converter: each 4-bit digit of its output feeds one instance of that converter.
- One input word is accepted per valid/ready handshake, converted over BIN_W clock cycles, and held as packed BCD until the consumer takes it.

---
 rtl/bin_to_bcd_seq_pkg.sv | 28 ++
 rtl/bin_to_bcd_seq_if.sv | 29 ++
 rtl/bin_to_bcd_seq_dabble_digit.sv | 18 +
 rtl/bin_to_bcd_seq.sv | 97 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;

  // Per-digit correction applied before each shift.
  localparam logic [DIGIT_W-1:0] DIG_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] DIG_ADDEND = 4'd3;

  // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
  function automatic bit bcd_fits(int bin_w, int digits);
    longint unsigned max_bin;
    longint unsigned dec_range;
    max_bin   = (64'd1 << bin_w) - 64'd1;
    dec_range = 64'd1;
    for (int i = 0; i < digits; i++) begin
      dec_range = dec_range * 64'd10;
    end
    return dec_range > max_bin;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready bus between a producer of binary words and the BCD converter.
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic [BIN_W-1:0]            bin_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [DIGIT_W*DIGITS-1:0]   bcd_out;
  logic                        busy;

  // Producer / consumer side.
  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, busy
  );

  // Converter side.
  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, busy
  );

endinterface

// File: rtl/bin_to_bcd_seq_dabble_digit.sv
// Single-digit double-dabble corrector: adds 3 when the digit is 5 or more.
// Wraps modulo 16 for the (unreachable in operation) inputs 10-15.
module dabble_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  // Conditional +3 so the following left shift carries correctly into the next digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= DIG_THRESH) begin
      digit_o = digit_i + DIG_ADDEND;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// The finished result lives in its own register so bcd_out keeps the last
// value while the accumulator is reused by the next conversion.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CAT_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);

  if (!bcd_fits(BIN_W, DIGITS)) begin : g_width_check
    $fatal(1, "bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_e              state_q,   state_d;
  logic [BIN_W-1:0]    bin_sh_q,  bin_sh_d;
  logic [BCD_W-1:0]    bcd_acc_q, bcd_acc_d;
  logic [BCD_W-1:0]    res_q,     res_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [BCD_W-1:0]    bcd_corr;
  logic [CAT_W-1:0]    shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    dabble_digit u_dabble (
      .digit_i (bcd_acc_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (bcd_corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign shifted = {bcd_corr, bin_sh_q} << 1;

  // Next-state and datapath updates for IDLE / SHIFT / DONE.
  always_comb begin
    state_d   = state_q;
    bin_sh_d  = bin_sh_q;
    bcd_acc_d = bcd_acc_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          bin_sh_d  = bus.bin_in;
          bcd_acc_d = '0;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_acc_d = shifted[CAT_W-1 -: BCD_W];
        bin_sh_d  = shifted[BIN_W-1:0];
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_LAST) begin
          res_d   = shifted[CAT_W-1 -: BCD_W];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bin_sh_q  <= '0;
      bcd_acc_q <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_sh_q  <= bin_sh_d;
      bcd_acc_q <= bcd_acc_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.bcd_out   = res_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: accepted words push their decimal
// conversion, the output monitor pops and compares on every handshake.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) bus ();

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] dig_in;
  logic [3:0] dig_out;
  dabble_digit u_dig (.digit_i(dig_in), .digit_o(dig_out));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_q[$];
  bit   sweep_on = 1'b0;
  int   sweep_out = 0;
  int   seen[4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    int n;
    bus.in_valid = 1'b1;
    bus.bin_in   = v;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      tick();
      n++;
    end
    check("send_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    check("wait_out", {31'd0, bus.out_valid}, 32'd1);
  endtask

  // Scoreboard monitor, sampling mid-cycle where inputs and outputs are stable.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_bcd(int'(bus.bin_in)));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got %0h expected no output", bus.bcd_out);
          end else begin
            check("sb_result", {20'd0, bus.bcd_out}, {20'd0, exp_q.pop_front()});
          end
          if (sweep_on) begin
            sweep_out++;
            seen[bus.bcd_out]++;
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit stable;
    int n1;
    logic [11:0] b;
    logic [3:0] x0, x1, x2;
    bit done;

    bus.in_valid  = 1'b0;
    bus.bin_in    = '0;
    bus.out_ready = 1'b0;

    // Digit corrector over its full input range.
    for (int i = 0; i < 16; i++) begin
      dig_in = 4'(i);
      #1;
      check("dabble_digit", {28'd0, dig_out}, (i >= 5) ? 32'((i + 3) % 16) : 32'(i));
    end

    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_bcd",       {20'd0, bus.bcd_out},   32'd0);

    // 1: zero, latency and return to IDLE.
    bus.out_ready = 1'b1;
    send(8'd0);
    check("busy_shift",     {31'd0, bus.busy},     32'd1);
    check("in_ready_shift", {31'd0, bus.in_ready}, 32'd0);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'd8);
    check("zero_bcd", {20'd0, bus.bcd_out}, 32'h000);
    tick();
    check("idle_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // 2: max value and Excess-3 digits of 99.
    send(8'd255);
    wait_out();
    check("bcd_255", {20'd0, bus.bcd_out}, 32'h255);
    tick();
    send(8'd99);
    wait_out();
    b  = bus.bcd_out;
    x0 = b[3:0] + 4'd3;
    x1 = b[7:4] + 4'd3;
    x2 = b[11:8] + 4'd3;
    check("xs3_d0", {28'd0, x0}, 32'hC);
    check("xs3_d1", {28'd0, x1}, 32'hC);
    check("xs3_d2", {28'd0, x2}, 32'h3);
    tick();

    // 3: backpressure holds the result.
    bus.out_ready = 1'b0;
    send(8'd137);
    wait_out();
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!bus.out_valid || bus.in_ready || bus.bcd_out !== 12'h137) stable = 1'b0;
    end
    check("bp_stable", {31'd0, stable}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("bp_hold",      {20'd0, bus.bcd_out},   32'h137);

    // 4: in_valid held during SHIFT/DONE is ignored.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.bin_in    = 8'd42;
    tick();
    bus.bin_in    = 8'd200;
    wait_out();
    check("ign_first", {20'd0, bus.bcd_out}, 32'h042);
    tick();
    check("ign_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    wait_out();
    check("ign_second", {20'd0, bus.bcd_out}, 32'h200);
    tick();

    // 5: reset during the 4th SHIFT cycle.
    send(8'd180);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_bcd",       {20'd0, bus.bcd_out},   32'd0);
    check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("mid_rst_busy",      {31'd0, bus.busy},      32'd0);
    send(8'd7);
    wait_out();
    check("post_rst_7", {20'd0, bus.bcd_out}, 32'h007);
    tick();

    // 6: full sweep with random output backpressure.
    for (int i = 0; i < 4096; i++) seen[i] = 0;
    sweep_on = 1'b1;
    done = 1'b0;
    fork
      begin
        for (int v = 0; v < 256; v++) send(8'(v));
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && (exp_q.size() != 0 || bus.out_valid); k++) tick();
    tick();
    sweep_on = 1'b0;
    check("sweep_count", 32'(sweep_out), 32'd256);
    n1 = 0;
    for (int i = 0; i < 4096; i++) if (seen[i] == 1) n1++;
    check("sweep_unique", 32'(n1), 32'd256);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
